// File: rtl/cpsr_flag_unit.sv
// rtl/cpsr_flag_unit.sv - NZCV flag register with EX/multiplier forwarding and ID stall
module cpsr_flag_unit #(
    parameter int MUL_LAT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ex_valid,
    input  logic       ex_s,
    input  logic [3:0] alu_flags,
    input  logic       msr_we,
    input  logic [3:0] msr_data,
    input  logic       mul_start,
    input  logic       mul_s,
    input  logic [3:0] mul_flags,
    input  logic       flush,
    input  logic       id_valid,
    input  logic [3:0] id_cc,
    output logic [3:0] flags_out,
    output logic [3:0] cpsr_q,
    output logic       mul_busy,
    output logic       stall_id
);

    localparam int CW = $clog2(MUL_LAT + 1);

    logic [CW-1:0] cnt;
    logic          pend;
    logic          ex_wr;
    logic [3:0]    ex_val;
    logic          complete;
    logic          mul_wr;
    logic          start_acc;

    assign ex_wr     = ex_valid & (msr_we | ex_s);
    assign ex_val    = msr_we ? msr_data : alu_flags;
    assign complete  = (cnt == CW'(1));
    assign mul_wr    = complete & pend & ~flush;
    assign start_acc = mul_start & (cnt == '0);
    assign mul_busy  = (cnt != '0);

    // EX is always younger than an in-flight multiply, so it wins the mux
    always_comb begin
        flags_out = cpsr_q;
        if (ex_wr) begin
            flags_out = ex_val;
        end else if (mul_wr) begin
            flags_out = mul_flags;
        end
    end

    assign stall_id = id_valid & (id_cc != 4'b1110) & (id_cc != 4'b1111)
                    & pend & ~complete & ~flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            pend   <= 1'b0;
            cpsr_q <= 4'b0000;
        end else begin
            // flush does not touch cnt: the multiplier drains on its own
            if (start_acc) begin
                cnt <= CW'(MUL_LAT);
            end else if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end

            if (start_acc && mul_s) begin
                pend <= 1'b1;
            end else if (complete || flush || ex_wr) begin
                pend <= 1'b0;
            end

            cpsr_q <= flags_out;
        end
    end

endmodule
